// File: rtl/jk_pkg.sv
`default_nettype none
// +---------------------------------------------------------------+
// | jk_pkg : JK bus codes and controller state encoding            |
// | Rev 1.0                                                        |
// +---------------------------------------------------------------+
package jk_pkg;

   localparam logic [1:0] JK_HOLD   = 2'b00;
   localparam logic [1:0] JK_RESET  = 2'b01;
   localparam logic [1:0] JK_SET    = 2'b10;
   localparam logic [1:0] JK_TOGGLE = 2'b11;

   typedef enum logic [1:0] {
      ST_INIT  = 2'd0,
      ST_DRIVE = 2'd1,
      ST_CHECK = 2'd2,
      ST_IDLE  = 2'd3
   } state_t;

endpackage
`default_nettype wire

// File: rtl/jk_excite.sv
`default_nettype none
// +---------------------------------------------------------------+
// | jk_excite : minimal JK excitation for one lane (shadow -> tgt) |
// | Rev 1.0                                                        |
// +---------------------------------------------------------------+
module jk_excite
   import jk_pkg::*;
#(
   parameter int PREFER_TOGGLE = 0
) (
   input  logic       q,
   input  logic       t,
   output logic [1:0] jk
);

   always_comb begin
      if (q == t)
         jk = JK_HOLD;
      else if (PREFER_TOGGLE != 0)
         jk = JK_TOGGLE;
      else if (t)
         jk = JK_SET;
      else
         jk = JK_RESET;
   end

endmodule
`default_nettype wire

// File: rtl/jk_drive_ctrl.sv
`default_nettype none
// +---------------------------------------------------------------+
// | jk_drive_ctrl : loads target values into an external JK flop   |
// | bank with one-cycle excitation and Q feedback checking.        |
// | Rev 1.0                                                        |
// +---------------------------------------------------------------+
module jk_drive_ctrl
   import jk_pkg::*;
#(
   parameter int N             = 4,
   parameter int PREFER_TOGGLE = 0,
   parameter int CHECK_EN      = 1
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           tgt_valid,
   output logic           tgt_ready,
   input  logic [N-1:0]   tgt_data,
   output logic [2*N-1:0] jk,
   input  logic [N-1:0]   q_fb,
   output logic           busy,
   output logic           done,
   output logic           err,
   output logic [N-1:0]   err_lanes,
   input  logic           err_clr
);

   state_t         r_state;
   state_t         w_state_nxt;
   logic           r_init_drv;
   logic           r_xfer;
   logic [N-1:0]   r_exp_q;
   logic [N-1:0]   w_mismatch;
   logic [2*N-1:0] w_code;
   logic           w_accept;

   for (genvar gi = 0; gi < N; gi++) begin : g_lane
      jk_excite #(.PREFER_TOGGLE(PREFER_TOGGLE)) u_excite (
         .q  (r_exp_q[gi]),
         .t  (tgt_data[gi]),
         .jk (w_code[2*gi+1:2*gi])
      );
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_state <= ST_INIT;
      else
         r_state <= w_state_nxt;
   end

   // INIT spends one cycle driving reset codes and one cycle settling before CHECK
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_INIT:  if (r_init_drv) w_state_nxt = ST_CHECK;
         ST_IDLE:  if (tgt_valid)  w_state_nxt = ST_DRIVE;
         ST_DRIVE: w_state_nxt = ST_CHECK;
         ST_CHECK: w_state_nxt = ST_IDLE;
         default:  w_state_nxt = ST_INIT;
      endcase
   end

   always_comb begin
      tgt_ready  = (r_state == ST_IDLE);
      busy       = (r_state != ST_IDLE);
      w_accept   = tgt_ready & tgt_valid;
      w_mismatch = ((r_state == ST_CHECK) && (CHECK_EN != 0)) ? (q_fb ^ r_exp_q) : '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         jk         <= '0;
         r_exp_q    <= '0;
         r_init_drv <= 1'b0;
         r_xfer     <= 1'b0;
         done       <= 1'b0;
         err        <= 1'b0;
         err_lanes  <= '0;
      end else begin
         done      <= (r_state == ST_CHECK) && r_xfer;
         // a fresh mismatch survives a simultaneous clear
         err_lanes <= (err_clr ? '0 : err_lanes) | w_mismatch;
         err       <= (err_clr ? 1'b0 : err) | (|w_mismatch);
         case (r_state)
            ST_INIT: begin
               r_exp_q    <= '0;
               r_xfer     <= 1'b0;
               r_init_drv <= 1'b1;
               jk         <= r_init_drv ? '0 : {N{JK_RESET}};
            end
            ST_IDLE: begin
               if (w_accept) begin
                  jk      <= w_code;
                  r_exp_q <= tgt_data;
                  r_xfer  <= 1'b1;
               end
            end
            ST_DRIVE: jk <= '0;
            ST_CHECK: begin
               jk         <= '0;
               r_xfer     <= 1'b0;
               r_init_drv <= 1'b0;
               if (|w_mismatch)
                  r_exp_q <= q_fb;
            end
            default: jk <= '0;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_jk_drive_ctrl.sv
`default_nettype none
// +---------------------------------------------------------------+
// | tb_jk_drive_ctrl : two controllers (set/reset and toggle mode) |
// | driving modelled JK flop banks. Rev 1.0                        |
// +---------------------------------------------------------------+
`timescale 1ns/1ps
module tb_jk_drive_ctrl;

   localparam int N = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic           rst_n;
   logic           tgt_valid;
   logic           err_clr;
   logic           preset;
   logic [N-1:0]   tgt_data;
   logic [N-1:0]   stuck0;
   logic [2*N-1:0] jk_o   [2];
   logic [N-1:0]   fq     [2];
   logic           tr_o   [2];
   logic           busy_o [2];
   logic           done_o [2];
   logic           err_o  [2];
   logic [N-1:0]   errl_o [2];

   logic [N-1:0]   m_exp  [2];
   logic [N-1:0]   m_errl [2];
   int n_vec = 0;
   int n_bad = 0;

   jk_drive_ctrl #(.N(N), .PREFER_TOGGLE(0), .CHECK_EN(1)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .tgt_valid(tgt_valid), .tgt_ready(tr_o[0]),
      .tgt_data(tgt_data), .jk(jk_o[0]), .q_fb(fq[0]), .busy(busy_o[0]),
      .done(done_o[0]), .err(err_o[0]), .err_lanes(errl_o[0]), .err_clr(err_clr)
   );

   jk_drive_ctrl #(.N(N), .PREFER_TOGGLE(1), .CHECK_EN(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .tgt_valid(tgt_valid), .tgt_ready(tr_o[1]),
      .tgt_data(tgt_data), .jk(jk_o[1]), .q_fb(fq[1]), .busy(busy_o[1]),
      .done(done_o[1]), .err(err_o[1]), .err_lanes(errl_o[1]), .err_clr(err_clr)
   );

   // external JK flop behaviour, with optional stuck-at-0 lanes
   function automatic logic [N-1:0] flop_next(input logic [N-1:0] q, input logic [2*N-1:0] c);
      logic [N-1:0] r;
      r = q;
      for (int i = 0; i < N; i++) begin
         case (c[2*i +: 2])
            2'b01:   r[i] = 1'b0;
            2'b10:   r[i] = 1'b1;
            2'b11:   r[i] = ~q[i];
            default: r[i] = q[i];
         endcase
      end
      return r;
   endfunction

   always @(posedge clk) begin
      if (preset) begin
         fq[0] <= '1;
         fq[1] <= '1;
      end else begin
         fq[0] <= flop_next(fq[0], jk_o[0]) & ~stuck0;
         fq[1] <= flop_next(fq[1], jk_o[1]) & ~stuck0;
      end
   end

   // the cheapest code that moves each lane from q to t
   function automatic logic [2*N-1:0] want_code(input logic [N-1:0] q, input logic [N-1:0] t, input bit tog);
      logic [2*N-1:0] c;
      c = '0;
      for (int i = 0; i < N; i++)
         if (q[i] != t[i])
            c[2*i +: 2] = tog ? 2'b11 : (t[i] ? 2'b10 : 2'b01);
      return c;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_init();
      tick();
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("d%0d_init_jk", k), 32'(jk_o[k]), 32'({N{2'b01}}));
         chk($sformatf("d%0d_init_rdy1", k), 32'(tr_o[k]), 32'd0);
      end
      tick();
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("d%0d_init_jk0", k), 32'(jk_o[k]), 32'd0);
         chk($sformatf("d%0d_init_rdy2", k), 32'(tr_o[k]), 32'd0);
         chk($sformatf("d%0d_init_q", k), 32'(fq[k]), 32'd0);
      end
      tick();
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("d%0d_init_rdy3", k), 32'(tr_o[k]), 32'd1);
         chk($sformatf("d%0d_init_err", k), 32'(err_o[k]), 32'd0);
         chk($sformatf("d%0d_init_done", k), 32'(done_o[k]), 32'd0);
         chk($sformatf("d%0d_init_errl", k), 32'(errl_o[k]), 32'd0);
         m_exp[k]  = '0;
         m_errl[k] = '0;
      end
   endtask

   task automatic xfer(input logic [N-1:0] t, input bit clr);
      logic [N-1:0] mis;
      tgt_valid = 1'b1;
      tgt_data  = t;
      tick();
      tgt_valid = 1'b0;
      tgt_data  = N'($urandom);
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("d%0d_drv_jk", k), 32'(jk_o[k]), 32'(want_code(m_exp[k], t, k == 1)));
         chk($sformatf("d%0d_drv_rdy", k), 32'(tr_o[k]), 32'd0);
         chk($sformatf("d%0d_drv_busy", k), 32'(busy_o[k]), 32'd1);
         chk($sformatf("d%0d_drv_done", k), 32'(done_o[k]), 32'd0);
      end
      tick();
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("d%0d_chk_jk", k), 32'(jk_o[k]), 32'd0);
         chk($sformatf("d%0d_chk_done", k), 32'(done_o[k]), 32'd0);
      end
      err_clr = clr;
      tick();
      err_clr = 1'b0;
      for (int k = 0; k < 2; k++) begin
         mis       = fq[k] ^ t;
         m_exp[k]  = (mis != '0) ? fq[k] : t;
         m_errl[k] = (clr ? '0 : m_errl[k]) | mis;
         chk($sformatf("d%0d_done", k), 32'(done_o[k]), 32'd1);
         chk($sformatf("d%0d_errl", k), 32'(errl_o[k]), 32'(m_errl[k]));
         chk($sformatf("d%0d_err", k), 32'(err_o[k]), 32'(|m_errl[k]));
         chk($sformatf("d%0d_rdy", k), 32'(tr_o[k]), 32'd1);
      end
   endtask

   initial begin
      rst_n     = 1'b0;
      preset    = 1'b1;
      tgt_valid = 1'b0;
      err_clr   = 1'b0;
      stuck0    = '0;
      tgt_data  = '0;
      repeat (3) tick();
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("d%0d_rst_jk", k), 32'(jk_o[k]), 32'd0);
         chk($sformatf("d%0d_rst_busy", k), 32'(busy_o[k]), 32'd1);
         chk($sformatf("d%0d_rst_rdy", k), 32'(tr_o[k]), 32'd0);
         chk($sformatf("d%0d_rst_done", k), 32'(done_o[k]), 32'd0);
         chk($sformatf("d%0d_rst_err", k), 32'(err_o[k]), 32'd0);
         chk($sformatf("d%0d_pre_q", k), 32'(fq[k]), 32'hF);
      end
      @(negedge clk);
      rst_n  = 1'b1;
      preset = 1'b0;
      run_init();

      xfer(4'b1010, 1'b0);
      xfer(4'b0110, 1'b0);
      stuck0 = 4'b0010;
      xfer(4'b0010, 1'b0);
      xfer(4'b0000, 1'b0);
      stuck0 = 4'b0001;
      xfer(4'b0001, 1'b1);
      stuck0 = '0;
      xfer(N'($urandom), 1'b1);

      for (int n = 0; n < 30; n++) begin
         stuck0 = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
         xfer(N'($urandom), $urandom_range(0, 3) == 0);
      end
      stuck0 = '0;

      // reset asserted in the middle of DRIVE
      tgt_valid = 1'b1;
      tgt_data  = N'($urandom);
      tick();
      tgt_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("d%0d_arst_jk", k), 32'(jk_o[k]), 32'd0);
         chk($sformatf("d%0d_arst_busy", k), 32'(busy_o[k]), 32'd1);
      end
      tick();
      for (int k = 0; k < 2; k++)
         chk($sformatf("d%0d_arst_done", k), 32'(done_o[k]), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      run_init();

      for (int n = 0; n < 8; n++)
         xfer(N'($urandom), 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
